cpu_spm_copy: RTL
=================

Name: cpu_spm_copy

Overview:
- Initiator-side engine for one scratch pad memory port; it sits in the requester role, where the SPM is the responder.
- Drives the SPM port protocol (addr, as_n, rw, wr_data, rd_data) to copy a block of words from a source to a destination address inside the SPM.
- Shares SPM port B with the MEM stage through a grant input. Software or a control register block starts it and observes busy/done.

Parameters:
- ADDR_W, 12, SPM word address width (matches the SPM address bus).
- DATA_W, 32, word data width.
- LEN_W, 13, transfer length width in words; 0 to 4096 words are legal.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request; sampled only in IDLE
- src_addr  input  ADDR_W  first source word address; sampled with start
- dst_addr  input  ADDR_W  first destination word address; sampled with start
- len  input  LEN_W  number of words; sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse
- spm_gnt  input  1  port grant from arbiter; when low, the engine must not access the port
- spm_addr  output  ADDR_W  SPM word address
- spm_as_n  output  1  address strobe, active low
- spm_rw  output  1  1 = READ, 0 = WRITE
- spm_wr_data  output  DATA_W  write data
- spm_rd_data  input  DATA_W  read data, valid the cycle after a read strobe

Behaviour:
- Reset values (asynchronous): state IDLE, busy 0, done 0, spm_as_n 1, spm_rw READ, spm_addr 0, spm_wr_data 0, all counters and data register 0.
- Reset mid-transfer: aborts immediately. No further strobes are issued, no done pulse, and already-written words stay written.
- States are IDLE, RD, WR, FIN.
- IDLE:
  - start=1 with len!=0 latches src/dst/len and moves to RD.
  - start=1 with len==0 moves to FIN with no port access.
  - start is ignored in every other state.
- RD:
  - Drives addr=src_ptr, rw=READ, as_n=!spm_gnt.
  - With gnt=1, the read is issued: src_ptr+1 and next state WR.
  - With gnt=0, holds the state and issues nothing.
- Read capture: rd_pend is set in the cycle after an issued read. In that cycle data_q <= spm_rd_data. spm_wr_data = rd_pend ? spm_rd_data : data_q, so a write in the very next cycle needs no extra latency.
- WR:
  - Drives addr=dst_ptr, rw=WRITE, as_n=!spm_gnt.
  - With gnt=1, the write is issued: dst_ptr+1, remaining-1, next state RD, or FIN if remaining becomes 0.
  - With gnt=0, holds and keeps data_q.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE. A start in the FIN cycle is ignored.
- Throughput: 2 cycles per word with gnt held high. An N-word copy from start to done takes 2N+2 cycles.
- Pointers wrap modulo 2^ADDR_W, so address 0xFFF is followed by 0x000.
- Copy is strictly ascending with no overlap correction. If dst is in (src, src+len), source data is overwritten before it is read; this is defined behaviour.
- spm_as_n/spm_rw/spm_addr are combinational from the state register, pointers and spm_gnt. There are no strobes outside RD/WR.
- busy is 1 in RD, WR and FIN.

Optional Feature:
- Macro: SPM_COPY_FILL_EN.
- When defined: adds inputs fill_mode (1) and fill_data (DATA_W), sampled with start.
  - With fill_mode=1 the engine skips RD and stays in WR, writing fill_data to dst_ptr each granted cycle: 1 cycle per word, N+2 cycles total.
  - With fill_mode=0, behaviour is the normal copy.
- When undefined: the ports do not exist and the engine only copies.

Test Plan:
- Preload SPM[0x010..0x013] = 0xA0..0xA3; start src=0x010 dst=0x100 len=4 with gnt=1 -> SPM[0x100..0x103]=0xA0..0xA3; done at cycle 10 after start; exactly 8 strobes alternating READ/WRITE.
- len=0 -> done pulse 2 cycles after start, spm_as_n never low, busy high 1 cycle.
- len=2 src=0x020 dst=0x200; drop gnt for 3 cycles during the first WR -> no strobe while gnt=0; written data equals SPM[0x020] unchanged; done delayed by exactly 3 cycles.
- src=0xFFE dst=0x300 len=3 -> reads 0xFFE, 0xFFF, 0x000; writes 0x300..0x302.
- Assert reset during the second WR of a len=4 copy -> as_n=1 same cycle, busy=0, no done; dst[2..3] unchanged.
- (FILL_EN) fill_mode=1 fill_data=0xDEADBEEF dst=0x040 len=3 -> SPM[0x040..0x042]=0xDEADBEEF; 3 WRITE strobes, no READ; done 5 cycles after start.

Source files
------------

// File: rtl/cpu_spm_copy_if.sv
// SPM port B bundle: the copy engine is the master and the SPM is the slave.
interface cpu_spm_copy_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  logic              spm_gnt;
  logic [ADDR_W-1:0] spm_addr;
  logic              spm_as_n;
  logic              spm_rw;
  logic [DATA_W-1:0] spm_wr_data;
  logic [DATA_W-1:0] spm_rd_data;

  modport master (
    input  spm_gnt, spm_rd_data,
    output spm_addr, spm_as_n, spm_rw, spm_wr_data
  );

  modport slave (
    input  spm_addr, spm_as_n, spm_rw, spm_wr_data,
    output spm_rd_data
  );
endinterface

// File: rtl/cpu_spm_copy.sv
// Word-by-word SPM block copy engine on a shared, grant-gated port: 2 cycles/word, 2N+2 start-to-done.
// Optional SPM_COPY_FILL_EN adds a pattern-fill mode (1 cycle/word) via fill_mode/fill_data.
module cpu_spm_copy #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
`ifdef SPM_COPY_FILL_EN
  input  logic              fill_mode,
  input  logic [DATA_W-1:0] fill_data,
`endif
  output logic              busy,
  output logic              done,
  cpu_spm_copy_if.master    spm
);

  typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic              rd_pend;
  logic [DATA_W-1:0] data_q;
  logic              fill_q;
  logic              start_fill;
  logic [DATA_W-1:0] copy_data;

`ifdef SPM_COPY_FILL_EN
  logic [DATA_W-1:0] fill_data_q;

  assign start_fill = fill_mode;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_data_q <= '0;
    end else if (state == IDLE && start) begin
      fill_data_q <= fill_data;
    end
  end

  assign spm.spm_wr_data = fill_q ? fill_data_q : copy_data;
`else
  assign start_fill      = 1'b0;
  assign spm.spm_wr_data = copy_data;
`endif

  // Read data is forwarded straight through in the cycle it arrives so the
  // write can follow immediately; data_q covers writes delayed by grant loss.
  assign copy_data = rd_pend ? spm.spm_rd_data : data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      rd_pend   <= 1'b0;
      data_q    <= '0;
      fill_q    <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= 1'b0;
      if (rd_pend) begin
        data_q <= spm.spm_rd_data;
      end
      case (state)
        IDLE: begin
          if (start) begin
            src_ptr   <= src_addr;
            dst_ptr   <= dst_addr;
            remaining <= len;
            fill_q    <= start_fill;
            busy      <= 1'b1;
            if (len == '0) begin
              state <= FIN;
            end else if (start_fill) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (spm.spm_gnt) begin
            src_ptr <= src_ptr + ADDR_W'(1);
            rd_pend <= 1'b1;
            state   <= WR;
          end
        end
        WR: begin
          if (spm.spm_gnt) begin
            dst_ptr   <= dst_ptr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state <= FIN;
            end else if (fill_q) begin
              state <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        FIN: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by the grant combinationally so a lost grant is honoured in the same cycle.
  always_comb begin
    spm.spm_addr = '0;
    spm.spm_as_n = 1'b1;
    spm.spm_rw   = 1'b1;
    case (state)
      RD: begin
        spm.spm_addr = src_ptr;
        spm.spm_as_n = ~spm.spm_gnt;
        spm.spm_rw   = 1'b1;
      end
      WR: begin
        spm.spm_addr = dst_ptr;
        spm.spm_as_n = ~spm.spm_gnt;
        spm.spm_rw   = 1'b0;
      end
      default: begin
        spm.spm_addr = '0;
        spm.spm_as_n = 1'b1;
        spm.spm_rw   = 1'b1;
      end
    endcase
  end

endmodule
